// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between the CPU memory path and
// the I/O port path. One transaction at a time; round-robin on contention.
// Optional build macro CPU_FIXED_PRIORITY_EN: CPU always wins a tie.
module ram_port_arbiter #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              Clock,
   input  logic              Clear,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              io_req,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_wdata,
   output logic              io_done,
   output logic [DATA_W-1:0] io_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy,
   output logic              grant_io
);

   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $fatal(1, "ram_port_arbiter: RD_LAT must be in 1..4");
   end

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      RESP
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                last_grant_io;
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic [2:0]          wait_cnt;
   logic                take;
   logic                pick_io;

   // RAM address and write data always reflect the latched transaction
   assign ram_addr = lat_addr;
   assign ram_din  = lat_wdata;

   // Arbitration: only sampled in IDLE; ties go to the requester not served last
   always_comb begin
      take    = 1'b0;
      pick_io = 1'b0;
      if (state == IDLE) begin
         if (cpu_req && io_req) begin
            take = 1'b1;
`ifdef CPU_FIXED_PRIORITY_EN
            pick_io = 1'b0;
`else
            pick_io = ~last_grant_io;
`endif
         end else if (cpu_req) begin
            take = 1'b1;
         end else if (io_req) begin
            take    = 1'b1;
            pick_io = 1'b1;
         end
      end
   end

   // Next-state and decoded outputs
   always_comb begin
      state_nxt = state;
      ram_we    = 1'b0;
      cpu_done  = 1'b0;
      io_done   = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (take) state_nxt = ACCESS;
         end
         ACCESS: begin
            ram_we    = lat_we;
            state_nxt = lat_we ? RESP : WAIT;
         end
         WAIT: begin
            if (wait_cnt == 3'd1) state_nxt = RESP;
         end
         RESP: begin
            cpu_done  = ~grant_io;
            io_done   = grant_io;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) state <= IDLE;
      else        state <= state_nxt;
   end

   // Latch the winning request and remember the owner
   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         grant_io      <= 1'b0;
         last_grant_io <= 1'b1;
         lat_we        <= 1'b0;
         lat_addr      <= '0;
         lat_wdata     <= '0;
      end else if (take) begin
         grant_io      <= pick_io;
         last_grant_io <= pick_io;
         lat_we        <= pick_io ? io_we    : cpu_we;
         lat_addr      <= pick_io ? io_addr  : cpu_addr;
         lat_wdata     <= pick_io ? io_wdata : cpu_wdata;
      end
   end

   // Read-latency counter and capture of read data into the owner's register
   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         wait_cnt  <= '0;
         cpu_rdata <= '0;
         io_rdata  <= '0;
      end else if (state == ACCESS && !lat_we) begin
         wait_cnt <= 3'(RD_LAT);
      end else if (state == WAIT) begin
         if (wait_cnt == 3'd1) begin
            if (grant_io) io_rdata  <= ram_dout;
            else          cpu_rdata <= ram_dout;
         end else begin
            wait_cnt <= wait_cnt - 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: one instance with RD_LAT=1 and one
// with RD_LAT=3, each attached to a behavioural RAM of matching latency.
module tb_ram_port_arbiter;
   localparam int AW = 9;
   localparam int DW = 32;

   logic Clock = 1'b0;
   logic Clear;
   always #5 Clock = ~Clock;

   logic          cpu_req, cpu_we, io_req, io_we;
   logic [AW-1:0] cpu_addr, io_addr, ram_addr;
   logic [DW-1:0] cpu_wdata, io_wdata, cpu_rdata, io_rdata, ram_din, ram_dout;
   logic          cpu_done, io_done, ram_we, busy, grant_io;

   logic          b_cpu_req, b_cpu_we, b_io_req, b_io_we;
   logic [AW-1:0] b_cpu_addr, b_io_addr, b_ram_addr;
   logic [DW-1:0] b_cpu_wdata, b_io_wdata, b_cpu_rdata, b_io_rdata, b_ram_din, b_ram_dout;
   logic          b_cpu_done, b_io_done, b_ram_we, b_busy, b_grant_io;

   int checks = 0;
   int errors = 0;

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
      .Clock(Clock), .Clear(Clear),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_done(io_done), .io_rdata(io_rdata),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
      .busy(busy), .grant_io(grant_io)
   );

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
      .Clock(Clock), .Clear(Clear),
      .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
      .cpu_done(b_cpu_done), .cpu_rdata(b_cpu_rdata),
      .io_req(b_io_req), .io_we(b_io_we), .io_addr(b_io_addr), .io_wdata(b_io_wdata),
      .io_done(b_io_done), .io_rdata(b_io_rdata),
      .ram_addr(b_ram_addr), .ram_din(b_ram_din), .ram_we(b_ram_we), .ram_dout(b_ram_dout),
      .busy(b_busy), .grant_io(b_grant_io)
   );

   // Behavioural RAMs: address sampled at a rising edge, data valid RD_LAT edges later
   logic [DW-1:0] mem1 [512];
   logic [DW-1:0] mem3 [512];
   logic [DW-1:0] r1;
   logic [DW-1:0] p3 [3];

   always @(posedge Clock) begin
      if (ram_we) mem1[ram_addr] <= ram_din;
      r1 <= mem1[ram_addr];
   end
   assign ram_dout = r1;

   always @(posedge Clock) begin
      if (b_ram_we) mem3[b_ram_addr] <= b_ram_din;
      p3[0] <= mem3[b_ram_addr];
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign b_ram_dout = p3[2];

   task automatic idle_inputs();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      io_req  = 1'b0; io_we  = 1'b0; io_addr  = '0; io_wdata  = '0;
      b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
      b_io_req  = 1'b0; b_io_we  = 1'b0; b_io_addr  = '0; b_io_wdata  = '0;
   endtask

   task automatic test_reset();
      Clear = 1'b0;
      idle_inputs();
      repeat (2) @(negedge Clock);
      checks++;
      if ({busy, grant_io, cpu_done, io_done, ram_we} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctl: got %b want 00000", {busy, grant_io, cpu_done, io_done, ram_we});
      end
      checks++;
      if ({ram_addr, ram_din} !== {(AW+DW){1'b0}}) begin
         errors++;
         $display("FAIL reset_ram_bus: got addr=%h din=%h want 0", ram_addr, ram_din);
      end
      checks++;
      if ({cpu_rdata, io_rdata} !== {(2*DW){1'b0}}) begin
         errors++;
         $display("FAIL reset_rdata: got cpu=%h io=%h want 0", cpu_rdata, io_rdata);
      end
      checks++;
      if ({b_busy, b_grant_io, b_cpu_done, b_io_done, b_ram_we} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctl3: got %b want 00000", {b_busy, b_grant_io, b_cpu_done, b_io_done, b_ram_we});
      end
      Clear = 1'b1;
   endtask

   task automatic test_cpu_write();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h005; cpu_wdata = 32'hDEADBEEF;
      @(negedge Clock);
      checks++;
      if ({ram_we, ram_addr, ram_din} !== {1'b1, 9'h005, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL wr_access: got we=%b addr=%h din=%h want 1/005/deadbeef", ram_we, ram_addr, ram_din);
      end
      checks++;
      if ({cpu_done, io_done, busy} !== 3'b001) begin
         errors++;
         $display("FAIL wr_access_ctl: got done/iodone/busy=%b want 001", {cpu_done, io_done, busy});
      end
      @(negedge Clock);
      checks++;
      if ({cpu_done, io_done, ram_we, grant_io} !== 4'b1000) begin
         errors++;
         $display("FAIL wr_done: got done/iodone/we/gio=%b want 1000", {cpu_done, io_done, ram_we, grant_io});
      end
      cpu_req = 1'b0;
      @(negedge Clock);
      checks++;
      if ({cpu_done, io_done, ram_we, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL wr_after: got done/iodone/we/busy=%b want 0000", {cpu_done, io_done, ram_we, busy});
      end
   endtask

   task automatic test_cpu_read();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005; cpu_wdata = '0;
      @(negedge Clock);
      checks++;
      if ({ram_we, busy, ram_addr} !== {1'b0, 1'b1, 9'h005}) begin
         errors++;
         $display("FAIL rd_access: got we=%b busy=%b addr=%h want 0/1/005", ram_we, busy, ram_addr);
      end
      @(negedge Clock);
      checks++;
      if ({cpu_done, busy, ram_we} !== 3'b010) begin
         errors++;
         $display("FAIL rd_wait: got done/busy/we=%b want 010", {cpu_done, busy, ram_we});
      end
      @(negedge Clock);
      checks++;
      if ({cpu_done, io_done} !== 2'b10 || cpu_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_done: got done=%b iodone=%b rdata=%h want 1/0/deadbeef", cpu_done, io_done, cpu_rdata);
      end
      cpu_req = 1'b0;
      @(negedge Clock);
      checks++;
      if (cpu_done !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_hold: got done=%b rdata=%h want 0/deadbeef", cpu_done, cpu_rdata);
      end
      // I/O overwrites the location; CPU read data must not move
      io_req = 1'b1; io_we = 1'b1; io_addr = 9'h005; io_wdata = 32'h12345678;
      @(negedge Clock);
      @(negedge Clock);
      checks++;
      if ({io_done, cpu_done, grant_io} !== 3'b101) begin
         errors++;
         $display("FAIL io_wr_done: got iodone/done/gio=%b want 101", {io_done, cpu_done, grant_io});
      end
      io_req = 1'b0;
      @(negedge Clock);
      checks++;
      if (cpu_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_hold_foreign: got %h want deadbeef", cpu_rdata);
      end
   endtask

   task automatic test_round_robin();
      int  waited;
      bit  exp_io;
      Clear = 1'b0;
      @(negedge Clock);
      Clear = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h010; cpu_wdata = 32'hC0C00001;
      io_req  = 1'b1; io_we  = 1'b1; io_addr  = 9'h011; io_wdata  = 32'h10100002;
      for (int n = 0; n < 6; n++) begin
         waited = 0;
         do begin
            @(negedge Clock);
            waited++;
         end while (!(cpu_done || io_done) && waited < 8);
`ifdef CPU_FIXED_PRIORITY_EN
         exp_io = 1'b0;
`else
         exp_io = (n % 2) == 1;
`endif
         checks++;
         if ({io_done, cpu_done, grant_io} !== {exp_io, ~exp_io, exp_io}) begin
            errors++;
            $display("FAIL rr_grant n=%0d: got iodone/done/gio=%b want %b", n,
                     {io_done, cpu_done, grant_io}, {exp_io, ~exp_io, exp_io});
         end
      end
      cpu_req = 1'b0;
      io_req  = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rr_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_clear_mid();
      io_req = 1'b1; io_we = 1'b0; io_addr = 9'h011; io_wdata = '0;
      @(negedge Clock);
      @(negedge Clock);
      checks++;
      if ({busy, io_done} !== 2'b10) begin
         errors++;
         $display("FAIL clr_wait: got busy/iodone=%b want 10", {busy, io_done});
      end
      #1 Clear = 1'b0;
      #1;
      checks++;
      if ({busy, grant_io, cpu_done, io_done, ram_we} !== 5'b0 ||
          {ram_addr, ram_din} !== {(AW+DW){1'b0}} ||
          {cpu_rdata, io_rdata} !== {(2*DW){1'b0}}) begin
         errors++;
         $display("FAIL clr_outputs: got ctl=%b addr=%h din=%h cpu=%h io=%h want all 0",
                  {busy, grant_io, cpu_done, io_done, ram_we}, ram_addr, ram_din, cpu_rdata, io_rdata);
      end
      io_req = 1'b0;
      @(negedge Clock);
      checks++;
      if ({io_done, busy} !== 2'b00) begin
         errors++;
         $display("FAIL clr_no_done: got iodone/busy=%b want 00", {io_done, busy});
      end
      Clear = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h020; cpu_wdata = 32'hA5A55A5A;
      @(negedge Clock);
      checks++;
      if ({ram_we, ram_addr, ram_din} !== {1'b1, 9'h020, 32'hA5A55A5A}) begin
         errors++;
         $display("FAIL clr_next_wr: got we=%b addr=%h din=%h want 1/020/a5a55a5a", ram_we, ram_addr, ram_din);
      end
      @(negedge Clock);
      checks++;
      if ({cpu_done, io_done} !== 2'b10) begin
         errors++;
         $display("FAIL clr_next_done: got done/iodone=%b want 10", {cpu_done, io_done});
      end
      cpu_req = 1'b0;
      @(negedge Clock);
   endtask

   task automatic test_rd_lat3();
      bit exp_busy;
      bit exp_done;
      b_io_req = 1'b1; b_io_we = 1'b1; b_io_addr = 9'h1FF; b_io_wdata = 32'h5EED1FFF;
      @(negedge Clock);
      @(negedge Clock);
      checks++;
      if (b_io_done !== 1'b1) begin
         errors++;
         $display("FAIL lat3_wr_done: got %b want 1", b_io_done);
      end
      b_io_req = 1'b0;
      @(negedge Clock);
      b_io_req = 1'b1; b_io_we = 1'b0; b_io_addr = 9'h1FF; b_io_wdata = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge Clock);
         exp_busy = (k <= 4);
         exp_done = (k == 4);
         checks++;
         if ({b_busy, b_io_done, b_cpu_done, b_ram_we} !== {exp_busy, exp_done, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL lat3_cycle k=%0d: got busy/iodone/done/we=%b want %b", k,
                     {b_busy, b_io_done, b_cpu_done, b_ram_we}, {exp_busy, exp_done, 2'b00});
         end
         if (k == 4) begin
            checks++;
            if (b_io_rdata !== 32'h5EED1FFF) begin
               errors++;
               $display("FAIL lat3_rdata: got %h want 5eed1fff", b_io_rdata);
            end
            b_io_req = 1'b0;
         end
      end
   endtask

   // Transaction-level reference: serial accesses against an array memory,
   // winner picked from the pending set, timing from the documented latencies.
   task automatic test_random();
      logic [DW-1:0] mm [512];
      bit            mv [512];
      int            idle_edge, g_edge, d_edge;
      bit            own_io, last_io, m_we, w, rd_ok, c_ok, i_ok;
      bit            e_busy, e_cd, e_id, e_we;
      logic [AW-1:0] m_addr;
      logic [DW-1:0] m_wdata, rd_val, c_rd, i_rd;
      Clear = 1'b0;
      idle_inputs();
      @(negedge Clock);
      Clear = 1'b1;
      for (int i = 0; i < 512; i++) mv[i] = 1'b0;
      idle_edge = 0; g_edge = -10; d_edge = -10;
      own_io = 1'b0; last_io = 1'b1; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      c_rd = '0; i_rd = '0; c_ok = 1'b1; i_ok = 1'b1; rd_ok = 1'b0; rd_val = '0;
      for (int k = 0; k < 400; k++) begin
         @(posedge Clock);
         if (k == d_edge && !m_we) begin
            if (own_io) begin i_rd = rd_val; i_ok = rd_ok; end
            else        begin c_rd = rd_val; c_ok = rd_ok; end
         end
         if (k >= idle_edge && (cpu_req || io_req)) begin
            if (cpu_req && io_req) begin
`ifdef CPU_FIXED_PRIORITY_EN
               w = 1'b0;
`else
               w = ~last_io;
`endif
            end else begin
               w = io_req;
            end
            own_io  = w;
            last_io = w;
            m_we    = w ? io_we    : cpu_we;
            m_addr  = w ? io_addr  : cpu_addr;
            m_wdata = w ? io_wdata : cpu_wdata;
            g_edge  = k;
            d_edge  = m_we ? k + 1 : k + 2;
            idle_edge = d_edge + 2;
            if (m_we) begin
               mm[m_addr] = m_wdata;
               mv[m_addr] = 1'b1;
            end else begin
               rd_val = mm[m_addr];
               rd_ok  = mv[m_addr];
            end
         end
         @(negedge Clock);
         e_busy = (k >= g_edge) && (k <= d_edge);
         e_cd   = (k == d_edge) && !own_io;
         e_id   = (k == d_edge) && own_io;
         e_we   = (k == g_edge) && m_we;
         checks++;
         if ({busy, cpu_done, io_done, ram_we, grant_io} !== {e_busy, e_cd, e_id, e_we, own_io}) begin
            errors++;
            $display("FAIL rnd_ctl k=%0d: got busy/done/iodone/we/gio=%b want %b", k,
                     {busy, cpu_done, io_done, ram_we, grant_io}, {e_busy, e_cd, e_id, e_we, own_io});
         end
         checks++;
         if (ram_addr !== m_addr || ram_din !== m_wdata) begin
            errors++;
            $display("FAIL rnd_bus k=%0d: got addr=%h din=%h want %h/%h", k, ram_addr, ram_din, m_addr, m_wdata);
         end
         if (c_ok) begin
            checks++;
            if (cpu_rdata !== c_rd) begin
               errors++;
               $display("FAIL rnd_cpu_rdata k=%0d: got %h want %h", k, cpu_rdata, c_rd);
            end
         end
         if (i_ok) begin
            checks++;
            if (io_rdata !== i_rd) begin
               errors++;
               $display("FAIL rnd_io_rdata k=%0d: got %h want %h", k, io_rdata, i_rd);
            end
         end
         if ((cpu_req && e_cd) || (!cpu_req && $urandom_range(2, 0) == 0)) begin
            cpu_req   = (!cpu_req) || ($urandom_range(1, 0) == 1);
            cpu_we    = 1'($urandom_range(1, 0));
            cpu_addr  = 9'($urandom_range(15, 0));
            cpu_wdata = $urandom;
         end
         if ((io_req && e_id) || (!io_req && $urandom_range(2, 0) == 0)) begin
            io_req   = (!io_req) || ($urandom_range(1, 0) == 1);
            io_we    = 1'($urandom_range(1, 0));
            io_addr  = 9'($urandom_range(15, 0));
            io_wdata = $urandom;
         end
      end
      idle_inputs();
      repeat (4) @(negedge Clock);
   endtask

   initial begin
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_round_robin();
      test_clear_mid();
      test_rd_lat3();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
